shift_seq_ctrl: RTL and testbench

- Sequencer for the serial-in/parallel-out shift register datapath.
- Accepts a parallel word on a valid/ready handshake and drives it MSB-first onto the register's serial input, with one shift strobe per bit.
- After the last shift it samples the register's parallel outputs and presents the captured word on a valid/ready output handshake.
- Sits between the word source and the shift register; it is the only agent driving that register's serial input.

---
 rtl/shift_seq_pkg.sv | 26 ++
 rtl/shift_strobe_gen.sv | 52 +++++
 rtl/shift_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg
//   Shared definitions for the shift-register sequencer:
//     - state_t     : controller state, 2-bit encoding
//     - DEFAULT_*   : default word width and strobe divider
//     - cnt_bits()  : width of a counter that must hold 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DIV   = 1;

    // A divider of 1 still needs a one-bit counter so the port and compare
    // logic stay well formed.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : shift_seq_pkg

// File: rtl/shift_strobe_gen.sv
// -----------------------------------------------------------------------------
// shift_strobe_gen
//   Rate divider for the shift strobe. While enabled, div_cnt runs 0..DIV-1
//   and wraps; the strobe is high on the last count. While disabled or
//   cleared the counter sits at zero, so every new word starts a fresh period.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   i_en        in   count enable (controller is shifting)
//   i_clr       in   synchronous clear, active high
//   o_shift_en  out  one-cycle strobe, decoded from the registered count
// -----------------------------------------------------------------------------
module shift_strobe_gen
    import shift_seq_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_shift_en
);

    localparam int               DCW      = cnt_bits(DIV);
    localparam logic [DCW-1:0]   DIV_LAST = DCW'(DIV - 1);

    logic [DCW-1:0] r_div_cnt;
    logic           w_last;

    assign w_last = (r_div_cnt == DIV_LAST);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_div_cnt <= '0;
        end else if (w_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DCW'(1);
        end
    end

    // Pure decode of a register: no combinational path from any input other
    // than the enable, which is itself a registered-state decode upstream.
    assign o_shift_en = i_en && w_last;

endmodule : shift_strobe_gen

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Sequencer for a serial-in/parallel-out shift register. A word accepted on
//   the input handshake is driven MSB-first onto the register's serial input,
//   one bit per shift strobe. One settle cycle after the last strobe the
//   register's parallel outputs are captured and offered on the output
//   handshake.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   clr        in   synchronous abort, active high (returns to IDLE)
//   in_valid   in   source word valid
//   in_ready   out  controller can accept a word (IDLE and not aborting)
//   in_data    in   word to serialise
//   ser_out    out  serial bit to the shift register
//   shift_en   out  one-cycle shift strobe for the shift register
//   par_in     in   shift register parallel outputs, [WIDTH-1] is the oldest bit
//   out_valid  out  captured word valid
//   out_ready  in   sink accepts the captured word
//   out_data   out  captured word
//   busy       out  high in every state except IDLE
// -----------------------------------------------------------------------------
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int             BCW      = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [BCW-1:0]   r_bit_cnt;
    logic [BCW-1:0]   w_bit_cnt_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic             w_shift_en;

    // -------------------------------------------------------------------------
    // Strobe generator: counts only while shifting, restarts on abort.
    // -------------------------------------------------------------------------
    shift_strobe_gen #(
        .DIV (DIV)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_state == SHIFT),
        .i_clr      (clr),
        .o_shift_en (w_shift_en)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first; a path that forgot one
        // would otherwise infer a latch.
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;

        if (clr) begin
            // Abort wins over everything except reset; the last captured word
            // is deliberately kept on out_data.
            w_state_nxt     = IDLE;
            w_bit_cnt_nxt   = '0;
            w_out_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_shadow_nxt  = in_data;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = SHIFT;
                    end
                end

                SHIFT: begin
                    if (w_shift_en) begin
                        w_shadow_nxt  = {r_shadow[WIDTH-2:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_nxt = SETTLE;
                        end
                    end
                end

                // One cycle for the last shifted bit to appear on par_in.
                SETTLE: begin
                    w_out_data_nxt  = par_in;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = HOLD;
                end

                HOLD: begin
                    if (out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_state_nxt     = IDLE;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_shadow    <= '0;
            r_bit_cnt   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Gating with rst keeps the source from seeing ready while held in reset.
    assign in_ready  = rst && (r_state == IDLE) && !clr;
    assign ser_out   = (r_state == SHIFT) ? r_shadow[WIDTH-1] : 1'b0;
    assign shift_en  = w_shift_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state != IDLE);

endmodule : shift_seq_ctrl

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Two controllers (DIV=1 and DIV=3, WIDTH=4), each feeding a behavioural
//   shift register. A transaction-level model per instance tracks the cycles
//   elapsed since the accept edge and derives every output from that count;
//   a compare process checks all outputs on each falling edge. Directed
//   scenarios add hand-computed literal expectations, then randomized
//   traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W = 4;

    logic clk;
    logic [1:0] rst, clr, in_valid, in_ready, ser_out, shift_en;
    logic [1:0] out_valid, out_ready, busy;
    logic [1:0][W-1:0] in_data, out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // -------------------------------------------------------------------------
    // Per-instance DUT, shift register and reference model
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int D = (g == 0) ? 1 : 3;

        logic [W-1:0] reg_q = '0;
        int           m_p    = 0;
        logic         m_idle = 1'b1;
        logic         m_hold = 1'b0;
        logic [W-1:0] m_word = '0;
        logic [W-1:0] m_out  = '0;

        shift_seq_ctrl #(.WIDTH(W), .DIV(D)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .clr       (clr[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .ser_out   (ser_out[g]),
            .shift_en  (shift_en[g]),
            .par_in    (reg_q),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );

        // The register the controller drives.
        always @(posedge clk) begin
            if (shift_en[g]) reg_q <= {reg_q[W-2:0], ser_out[g]};
        end

        // m_p = edges since accept. Shifting for m_p in [0, W*D-1], settle at
        // m_p == W*D, word offered from m_p == W*D+1 until taken.
        always @(posedge clk or negedge rst[g]) begin
            if (!rst[g]) begin
                m_idle <= 1'b1;
                m_hold <= 1'b0;
                m_p    <= 0;
                m_out  <= '0;
            end else if (clr[g]) begin
                m_idle <= 1'b1;
                m_hold <= 1'b0;
            end else if (m_idle) begin
                if (in_valid[g]) begin
                    m_idle <= 1'b0;
                    m_word <= in_data[g];
                    m_p    <= 0;
                end
            end else if (m_hold) begin
                if (out_ready[g]) begin
                    m_hold <= 1'b0;
                    m_idle <= 1'b1;
                end
            end else begin
                m_p <= m_p + 1;
                if (m_p + 1 == W * D + 1) begin
                    m_hold <= 1'b1;
                    m_out  <= m_word;
                end
            end
        end

        always @(negedge clk) begin : cmp
            logic e_rdy, e_busy, e_ser, e_sen;
            e_rdy  = rst[g] && m_idle && !clr[g];
            e_busy = !m_idle;
            e_ser  = 1'b0;
            e_sen  = 1'b0;
            if (!m_idle && !m_hold && m_p < W * D) begin
                e_ser = m_word[W - 1 - m_p / D];
                e_sen = ((m_p + 1) % D) == 0;
            end
            check($sformatf("g%0d in_ready", g),  in_ready[g],  e_rdy);
            check($sformatf("g%0d busy", g),      busy[g],      e_busy);
            check($sformatf("g%0d ser_out", g),   ser_out[g],   e_ser);
            check($sformatf("g%0d shift_en", g),  shift_en[g],  e_sen);
            check($sformatf("g%0d out_valid", g), out_valid[g], m_hold);
            check($sformatf("g%0d out_data", g),  out_data[g],  m_out);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change only 1 time unit after a rising edge)
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word until accepted; returns just after the accept edge (T0).
    task automatic send(input int g, input logic [W-1:0] w);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        in_data[g]  = w;
        in_valid[g] = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready[g];
            tick();
            if (rdy) ok = 1'b1;
        end
        in_valid[g] = 1'b0;
        check($sformatf("g%0d accept", g), ok, 1'b1);
    endtask

    // Observe n cycles after T0; p is the number of edges since T0.
    task automatic trace(input int g, input int d, input int n,
                         output int strobes, output int bad_pos,
                         output logic [W-1:0] bits, output int first_v,
                         output int nv, output logic [W-1:0] dv);
        strobes = 0; bad_pos = 0; bits = '0; first_v = -1; nv = 0; dv = '0;
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            if (shift_en[g]) begin
                strobes++;
                bits = {bits[W-2:0], ser_out[g]};
                if (((p + 1) % d) != 0) bad_pos++;
            end
            if (out_valid[g]) begin
                if (first_v < 0) begin
                    first_v = p;
                    dv      = out_data[g];
                end
                nv++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int strobes, bad_pos, first_v, nv;
        logic [W-1:0] bits, dv;
        bit seen;

        rst = 2'b00; clr = 2'b00; in_valid = 2'b00; out_ready = 2'b00;
        in_data = '0;

        // Reset held with random inputs.
        for (int c = 0; c < 5; c++) begin
            tick();
            for (int g = 0; g < 2; g++) begin
                in_valid[g]  = 1'($urandom_range(0, 1));
                clr[g]       = 1'($urandom_range(0, 1));
                out_ready[g] = 1'($urandom_range(0, 1));
                in_data[g]   = W'($urandom);
            end
        end
        @(negedge clk);
        check("rst out_valid", out_valid, 2'b00);
        check("rst shift_en",  shift_en,  2'b00);
        check("rst busy",      busy,      2'b00);
        tick();
        clr = 2'b00; in_valid = 2'b00; out_ready = 2'b11;
        rst = 2'b11;
        @(negedge clk);
        check("post-rst in_ready", in_ready, 2'b11);
        tick();

        // Single word, DIV=1.
        send(0, 4'b1010);
        trace(0, 1, 10, strobes, bad_pos, bits, first_v, nv, dv);
        check("w1010 strobes",   strobes, 4);
        check("w1010 ser bits",  bits,    4'b1010);
        check("w1010 valid at",  first_v, 5);
        check("w1010 valid len", nv,      1);
        check("w1010 out_data",  dv,      4'b1010);
        tick();

        // Rate divider, DIV=3.
        send(1, 4'b0110);
        trace(1, 3, 20, strobes, bad_pos, bits, first_v, nv, dv);
        check("div3 strobes",   strobes, 4);
        check("div3 strobe pos", bad_pos, 0);
        check("div3 ser bits",  bits,    4'b0110);
        check("div3 valid at",  first_v, 13);
        check("div3 valid len", nv,      1);
        check("div3 out_data",  dv,      4'b0110);
        tick();

        // Backpressure.
        out_ready[0] = 1'b0;
        send(0, 4'b1100);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check("bp valid seen", seen, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("bp out_valid", out_valid[0], 1'b1);
            check("bp out_data",  out_data[0],  4'b1100);
            check("bp in_ready",  in_ready[0],  1'b0);
        end
        tick();
        out_ready[0] = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("bp release in_ready",  in_ready[0],  1'b1);
        check("bp release out_valid", out_valid[0], 1'b0);
        tick();

        // Abort after the second strobe.
        send(0, 4'b1111);
        tick();
        tick();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        @(negedge clk);
        check("abort busy", busy[0], 1'b0);
        trace(0, 1, 8, strobes, bad_pos, bits, first_v, nv, dv);
        check("abort no valid", nv, 0);
        tick();
        send(0, 4'b0001);
        trace(0, 1, 10, strobes, bad_pos, bits, first_v, nv, dv);
        check("post-abort out_data", dv,      4'b0001);
        check("post-abort valid at", first_v, 5);
        tick();

        // Asynchronous reset between edges while shifting.
        send(1, 4'b1111);
        @(negedge clk);
        check("arst pre busy", busy[1],    1'b1);
        check("arst pre ser",  ser_out[1], 1'b1);
        #2;
        rst[1] = 1'b0;
        #1;
        check("arst busy",      busy[1],      1'b0);
        check("arst ser_out",   ser_out[1],   1'b0);
        check("arst shift_en",  shift_en[1],  1'b0);
        check("arst out_valid", out_valid[1], 1'b0);
        check("arst out_data",  out_data[1],  4'b0000);
        tick();
        tick();
        rst[1] = 1'b1;
        tick();

        // Randomized traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            for (int g = 0; g < 2; g++) begin
                in_valid[g]  = 1'($urandom_range(0, 1));
                in_data[g]   = W'($urandom);
                out_ready[g] = ($urandom_range(0, 3) != 0);
                clr[g]       = ($urandom_range(0, 39) == 0);
            end
            tick();
        end
        clr = 2'b00; in_valid = 2'b00;
        tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_shift_seq_ctrl
